// File: rtl/nn_pkg.sv
// Shared types for the z/m dot-product path.
// Q8.8 operands, result FIFO entries, accumulator FSM states.
package nn_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic signed [15:0] q8_8_t;

  typedef struct packed {
    logic        sat;
    logic [15:0] value;
  } result_entry_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO.
// Head is visible combinationally; reads as zero when empty.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a push when a pop frees the slot
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      if (do_push)
        wr_ptr <= nxt(wr_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Q8.8 multiply-accumulate over z/m vectors.
// Rounds, saturates and optionally rectifies each sum into a FIFO.
module dot_product_accumulator
  import nn_pkg::*;
#(
  parameter int FRAC_BITS  = nn_pkg::FRAC_BITS,
  parameter int ACC_WIDTH  = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int RELU       = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        en,
  input  q8_8_t       z_element,
  input  q8_8_t       m_element,
  input  logic        element_valid,
  input  logic        last_element,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_saturated,
  output logic        result_valid,
  input  logic        result_read,
  output logic        fifo_full,
  output logic        dropped
);

  localparam logic signed [ACC_WIDTH-1:0] HALF =
    ACC_WIDTH'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [ACC_WIDTH-1:0] MAX_R =
    ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] MIN_R =
    ACC_WIDTH'(-32768);

  acc_state_t state;
  logic       accept;
  logic       first;

  logic                        p_valid;
  logic                        p_first;
  logic                        p_last;
  logic signed [31:0]          prod;

  logic                        a_valid;
  logic                        a_last;
  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [ACC_WIDTH-1:0] rounded;
  result_entry_t               entry;
  result_entry_t               head;
  logic                        push;
  logic                        empty;

  assign accept = element_valid & en;
  assign first  = (state == IDLE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else if (accept) begin
      unique case (state)
        IDLE:  state <= last_element ? IDLE : ACCUM;
        ACCUM: state <= last_element ? IDLE : ACCUM;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_first <= first;
        p_last  <= last_element;
        prod    <= z_element * m_element;
      end
    end
  end

  // first reloads so back-to-back vectors need no bubble
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      acc     <= '0;
    end else begin
      a_valid <= p_valid;
      if (p_valid) begin
        a_last <= p_last;
        acc    <= p_first ? ACC_WIDTH'(prod)
                          : acc + ACC_WIDTH'(prod);
      end
    end
  end

  assign rounded = (acc + HALF) >>> FRAC_BITS;
  assign push    = a_valid & a_last;

  always_comb begin
    entry = '0;
    unique case (1'b1)
      (rounded > MAX_R): begin
        entry.sat   = 1'b1;
        entry.value = 16'h7FFF;
      end
      (rounded < MIN_R): begin
        entry.sat   = 1'b1;
        entry.value = 16'h8000;
      end
      default: entry.value = rounded[15:0];
    endcase
    if (RELU != 0 && entry.value[15])
      entry.value = '0;
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(result_entry_t))
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .push    (push),
    .wr_data (entry),
    .pop     (result_read),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (empty)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      dropped <= 1'b0;
    else if (push && fifo_full && !result_read)
      dropped <= 1'b1;
  end

  assign result           = head.value;
  assign result_saturated = head.sat;
  assign result_valid     = ~empty;
  assign busy = (state == ACCUM) | p_valid | a_valid;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: directed cases plus random traffic.
// A queue-based model predicts every output each cycle.
module tb_dot_product_accumulator;

  localparam int DEPTH = 4;

  logic               clock = 1'b0;
  logic               clear = 1'b0;
  logic               en = 1'b1;
  logic signed [15:0] z_element = '0;
  logic signed [15:0] m_element = '0;
  logic               element_valid = 1'b0;
  logic               last_element = 1'b0;
  logic               result_read = 1'b0;

  logic        busy, result_saturated, result_valid;
  logic        fifo_full, dropped;
  logic [15:0] result;
  logic        busy0, sat0, rv0, full0, drop0;
  logic [15:0] result0;

  always #5 clock = ~clock;

  dot_product_accumulator #(.RELU(1)) dut (
    .clock            (clock),
    .clear            (clear),
    .en               (en),
    .z_element        (z_element),
    .m_element        (m_element),
    .element_valid    (element_valid),
    .last_element     (last_element),
    .busy             (busy),
    .result           (result),
    .result_saturated (result_saturated),
    .result_valid     (result_valid),
    .result_read      (result_read),
    .fifo_full        (fifo_full),
    .dropped          (dropped)
  );

  dot_product_accumulator #(.RELU(0)) dut0 (
    .clock            (clock),
    .clear            (clear),
    .en               (en),
    .z_element        (z_element),
    .m_element        (m_element),
    .element_valid    (element_valid),
    .last_element     (last_element),
    .busy             (busy0),
    .result           (result0),
    .result_saturated (sat0),
    .result_valid     (rv0),
    .result_read      (result_read),
    .fifo_full        (full0),
    .dropped          (drop0)
  );

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;
  bit check_on = 0;

  longint mq[$];
  longint pend_acc[$];
  int     pend_due[$];
  longint macc = 0;
  bit     open = 0;
  bit     drop_m = 0;
  int     edge_n = 0;
  bit     acc_now = 0;
  bit     acc_prev = 0;
  bit     pop_m, full_b;

  function automatic logic [16:0] entry_of(input longint a,
                                           input bit relu);
    longint r;
    bit sat;
    r = (a + 128) >>> 8;
    sat = 0;
    if (r > 32767) begin
      r = 32767;
      sat = 1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1;
    end
    if (relu && r < 0)
      r = 0;
    return {sat, 16'(r)};
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // vector sums are exact integers; push lands two edges after last
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      mq.delete();
      pend_acc.delete();
      pend_due.delete();
      macc = 0;
      open = 0;
      drop_m = 0;
      edge_n = 0;
      acc_now = 0;
      acc_prev = 0;
    end else begin
      edge_n++;
      full_b = (mq.size() == DEPTH);
      pop_m = result_read && (mq.size() > 0);
      if (pop_m)
        void'(mq.pop_front());
      if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
        if (full_b && !pop_m)
          drop_m = 1;
        else
          mq.push_back(pend_acc[0]);
        void'(pend_acc.pop_front());
        void'(pend_due.pop_front());
      end
      acc_prev = acc_now;
      acc_now = element_valid && en;
      if (acc_now) begin
        if (!open)
          macc = 0;
        macc += longint'(z_element) * longint'(m_element);
        if (last_element) begin
          pend_acc.push_back(macc);
          pend_due.push_back(edge_n + 2);
          open = 0;
        end else begin
          open = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [16:0] e1, e0;
    if (check_on) begin
      vectors++;
      e1 = (mq.size() > 0) ? entry_of(mq[0], 1) : '0;
      e0 = (mq.size() > 0) ? entry_of(mq[0], 0) : '0;
      chk("result_valid", result_valid, mq.size() > 0);
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("dropped", dropped, drop_m);
      chk("busy", busy, open || acc_now || acc_prev);
      chk("result", result, e1[15:0]);
      chk("result_saturated", result_saturated, e1[16]);
      chk("result_norelu", result0, e0[15:0]);
      chk("sat_norelu", sat0, e0[16]);
    end
  end

  task automatic drive(input logic v, input logic l,
                       input logic [15:0] z,
                       input logic [15:0] m);
    @(negedge clock);
    en = 1'b1;
    element_valid = v;
    last_element = l;
    z_element = z;
    m_element = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic pop_expect(input string name,
                            input logic [15:0] v,
                            input logic s);
    @(negedge clock);
    chk(name, result, v);
    chk({name, "_sat"}, result_saturated, s);
    result_read = 1'b1;
    @(negedge clock);
    result_read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      result_read = result_valid;
    end
    result_read = 1'b0;
  endtask

  initial begin
    #1 clear = 1'b1;
    #1;
    chk("rst_result", result, 0);
    chk("rst_sat", result_saturated, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_busy", busy, 0);
    #20;
    @(negedge clock);
    clear = 1'b0;
    check_on = 1;

    for (int i = 0; i < 4; i++)
      drive(1'b1, i == 3, 16'h0100, 16'h0200);
    idle(1);
    chk("lat_e0", result_valid, 0);
    idle(1);
    chk("lat_e1", result_valid, 0);
    idle(1);
    chk("lat_e2", result_valid, 1);
    chk("sum4", result, 16'h0800);
    chk("sum4_sat", result_saturated, 0);
    drain();

    drive(1'b1, 1'b1, 16'h0001, 16'h0080);
    drive(1'b1, 1'b1, 16'h0001, 16'h007F);
    idle(3);
    pop_expect("round_up", 16'h0001, 1'b0);
    pop_expect("round_down", 16'h0000, 1'b0);

    for (int i = 0; i < 16; i++)
      drive(1'b1, i == 15, 16'h7FFF, 16'h7FFF);
    idle(3);
    pop_expect("sat_pos", 16'h7FFF, 1'b1);

    for (int i = 0; i < 3; i++)
      drive(1'b1, i == 2, 16'h0100, 16'hFF00);
    idle(3);
    chk("neg_norelu", result0, 16'hFD00);
    chk("neg_norelu_sat", sat0, 0);
    pop_expect("neg_relu", 16'h0000, 1'b0);

    for (int k = 1; k <= 5; k++)
      drive(1'b1, 1'b1, 16'h0100, 16'(k << 8));
    idle(2);
    chk("full_after4", fifo_full, 1);
    chk("no_drop_yet", dropped, 0);
    idle(1);
    chk("drop_5th", dropped, 1);
    pop_expect("pop1", 16'h0100, 1'b0);
    pop_expect("pop2", 16'h0200, 1'b0);
    pop_expect("pop3", 16'h0300, 1'b0);
    pop_expect("pop4", 16'h0400, 1'b0);
    @(negedge clock);
    chk("empty_after_pops", result_valid, 0);

    drive(1'b1, 1'b1, 16'h0300, 16'h0100);
    drive(1'b1, 1'b0, 16'h0100, 16'h0100);
    drive(1'b1, 1'b0, 16'h0100, 16'h0100);
    @(posedge clock);
    #2;
    element_valid = 1'b0;
    chk("pre_clear_busy", busy, 1);
    chk("pre_clear_valid", result_valid, 1);
    clear = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_valid", result_valid, 0);
    chk("clr_result", result, 0);
    chk("clr_dropped", dropped, 0);
    chk("clr_full", fifo_full, 0);
    #1 clear = 1'b0;
    drive(1'b1, 1'b0, 16'h0100, 16'h0100);
    drive(1'b1, 1'b1, 16'h0100, 16'h0100);
    idle(3);
    pop_expect("after_clear", 16'h0200, 1'b0);

    drive(1'b1, 1'b0, 16'h0100, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      en = 1'b0;
      element_valid = (i % 2) == 0;
      last_element = (i == 1);
      z_element = 16'h7FFF;
      m_element = 16'h7FFF;
    end
    drive(1'b1, 1'b1, 16'h0100, 16'h0300);
    idle(3);
    pop_expect("en_gap", 16'h0400, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      en = ($urandom_range(0, 3) != 0);
      element_valid = $urandom_range(0, 1);
      last_element = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0)
        z_element = 16'($urandom);
      else
        z_element = 16'(int'($urandom_range(0, 1023)) - 512);
      if ($urandom_range(0, 3) == 0)
        m_element = 16'($urandom);
      else
        m_element = 16'(int'($urandom_range(0, 1023)) - 512);
      result_read = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clock);
        #2 clear = 1'b1;
        #1 clear = 1'b0;
      end
    end
    idle(4);
    drain();
    check_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
